approx_mul_err_sweep: RTL

APPROX_MUL_ERR_SWEEP -- requirements
Module: approx_mul_err_sweep

---
 rtl/approx_mul_err_sweep_pkg.sv | 26 ++
 rtl/mul_ref_delay.sv | 49 ++++
 rtl/approx_mul_err_sweep.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/approx_mul_err_sweep_pkg.sv
// Shared types and width helpers for the approximate-multiplier error sweeper.
package approx_mul_err_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic MODE_DIAG = 1'b0;
  localparam logic MODE_EXH  = 1'b1;

  localparam int unsigned MAX_DUT_LATENCY = 15;

  // Product width for a given operand width.
  function automatic int unsigned prod_w(input int unsigned dw);
    return 2 * dw;
  endfunction

  // Error-counter width: one extra bit so an exhaustive sweep cannot saturate it.
  function automatic int unsigned cnt_w(input int unsigned dw);
    return 2 * dw + 1;
  endfunction

endpackage

// File: rtl/mul_ref_delay.sv
// Valid-tagged delay line carrying the reference product alongside the DUT pipeline.
module mul_ref_delay #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic w_unused_clk_rst;
      assign w_unused_clk_rst = clk ^ rst;
      assign out_valid        = in_valid & ~flush;
      assign out_data         = in_data;
    end else begin : g_pipe
      logic [DEPTH-1:0] r_valid;
      logic [WIDTH-1:0] r_data [DEPTH];

      // Valid bits are cleared on reset and on abort; payload needs no reset.
      always_ff @(posedge clk) begin
        if (rst || flush) begin
          r_valid <= '0;
        end else begin
          r_valid[0] <= in_valid;
          for (int unsigned i = 1; i < DEPTH; i++) begin
            r_valid[i] <= r_valid[i-1];
          end
        end
      end

      always_ff @(posedge clk) begin
        r_data[0] <= in_data;
        for (int unsigned i = 1; i < DEPTH; i++) begin
          r_data[i] <= r_data[i-1];
        end
      end

      assign out_valid = r_valid[DEPTH-1];
      assign out_data  = r_data[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/approx_mul_err_sweep.sv
// Drives operand sweeps into an approximate multiplier and accumulates
// error statistics against the exact product.
module approx_mul_err_sweep
  import approx_mul_err_sweep_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned DUT_LATENCY = 0,
  parameter int unsigned SUM_WIDTH   = 4 * DATA_WIDTH + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    mode,
  input  logic [DATA_WIDTH-1:0]   a_init,
  input  logic [DATA_WIDTH-1:0]   b_init,
  output logic [DATA_WIDTH-1:0]   op_a,
  output logic [DATA_WIDTH-1:0]   op_b,
  input  logic [2*DATA_WIDTH-1:0] dut_result,
  output logic                    busy,
  output logic                    done,
  output logic [2*DATA_WIDTH:0]   err_count,
  output logic [2*DATA_WIDTH-1:0] max_abs_err,
  output logic [SUM_WIDTH-1:0]    sum_abs_err,
  output logic [DATA_WIDTH-1:0]   worst_a,
  output logic [DATA_WIDTH-1:0]   worst_b
);

  localparam int unsigned DW  = DATA_WIDTH;
  localparam int unsigned PW  = prod_w(DATA_WIDTH);
  localparam int unsigned CW  = cnt_w(DATA_WIDTH);
  localparam int unsigned EW  = ((SUM_WIDTH > PW) ? SUM_WIDTH : PW) + 1;
  localparam int unsigned DLW = 1 + 2 * DW + PW;

  state_e r_state;
  state_e w_next;

  logic          r_mode;
  logic [DW-1:0] r_nxt_a;
  logic [DW-1:0] r_nxt_b;
  logic [PW-1:0] r_idx;
  logic          r_issue_done;
  logic [DW-1:0] r_op_a;
  logic [DW-1:0] r_op_b;
  logic          r_op_valid;
  logic          r_op_last;
  logic          r_busy;
  logic          r_done;

  logic [CW-1:0]        r_err_count;
  logic [PW-1:0]        r_max_abs_err;
  logic [SUM_WIDTH-1:0] r_sum_abs_err;
  logic [DW-1:0]        r_worst_a;
  logic [DW-1:0]        r_worst_b;

  logic                 w_start_take;
  logic                 w_issue;
  logic                 w_last_vec;
  logic [PW-1:0]        w_exact;
  logic [DLW-1:0]       w_dl_in;
  logic [DLW-1:0]       w_dl_out;
  logic                 w_cmp_valid;
  logic                 w_cmp_last;
  logic [DW-1:0]        w_cmp_a;
  logic [DW-1:0]        w_cmp_b;
  logic [PW-1:0]        w_cmp_exact;
  logic [PW-1:0]        w_abs_err;
  logic [EW-1:0]        w_sum_ext;
  logic [SUM_WIDTH-1:0] w_sum_sat;
  logic                 w_err_inc;

  assign w_start_take = start && !abort && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_issue      = (r_state == ST_SWEEP) && !r_issue_done && !abort;
  // Diagonal sweeps end after 2^DW vectors, exhaustive after 2^(2*DW).
  assign w_last_vec   = (&r_idx[DW-1:0]) && ((r_mode == MODE_DIAG) || (&r_idx[PW-1:DW]));

  // Next-state logic: a sweep finishes on the compare of its final vector.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) w_next = ST_SWEEP;
      end
      ST_SWEEP: begin
        if (w_cmp_valid && w_cmp_last) w_next = ST_DONE;
        else if (r_issue_done)         w_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_cmp_valid && w_cmp_last) w_next = ST_DONE;
      end
      default: w_next = ST_IDLE;
    endcase
    if (abort) w_next = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == ST_SWEEP) || (w_next == ST_DRAIN);
      r_done  <= (w_next == ST_DONE);
    end
  end

  // Vector generator: op_a is the inner index, op_b carries on op_a wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode       <= MODE_DIAG;
      r_nxt_a      <= '0;
      r_nxt_b      <= '0;
      r_idx        <= '0;
      r_issue_done <= 1'b0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_op_valid   <= 1'b0;
      r_op_last    <= 1'b0;
    end else begin
      r_op_valid <= w_issue;
      r_op_last  <= w_issue && w_last_vec;
      if (w_start_take) begin
        r_mode       <= mode;
        r_nxt_a      <= (mode == MODE_EXH) ? '0 : a_init;
        r_nxt_b      <= (mode == MODE_EXH) ? '0 : b_init;
        r_idx        <= '0;
        r_issue_done <= 1'b0;
      end else if (w_issue) begin
        r_op_a  <= r_nxt_a;
        r_op_b  <= r_nxt_b;
        r_idx   <= r_idx + PW'(1);
        r_nxt_a <= r_nxt_a + DW'(1);
        if ((r_mode == MODE_DIAG) || (&r_nxt_a)) r_nxt_b <= r_nxt_b + DW'(1);
        if (w_last_vec) r_issue_done <= 1'b1;
      end
    end
  end

  assign w_exact = PW'(r_op_a) * PW'(r_op_b);
  assign w_dl_in = {r_op_last, r_op_a, r_op_b, w_exact};

  mul_ref_delay #(
    .WIDTH (DLW),
    .DEPTH (DUT_LATENCY)
  ) u_ref_delay (
    .clk       (clk),
    .rst       (rst),
    .flush     (abort),
    .in_valid  (r_op_valid),
    .in_data   (w_dl_in),
    .out_valid (w_cmp_valid),
    .out_data  (w_dl_out)
  );

  assign {w_cmp_last, w_cmp_a, w_cmp_b, w_cmp_exact} = w_dl_out;

  assign w_abs_err = (dut_result >= w_cmp_exact) ? (dut_result - w_cmp_exact)
                                                 : (w_cmp_exact - dut_result);
  assign w_err_inc = (w_abs_err != '0) && (r_err_count != '1);
  assign w_sum_ext = EW'(r_sum_abs_err) + EW'(w_abs_err);
  assign w_sum_sat = (w_sum_ext > EW'({SUM_WIDTH{1'b1}})) ? {SUM_WIDTH{1'b1}}
                                                          : w_sum_ext[SUM_WIDTH-1:0];

  // Statistics: cleared on start, frozen on abort, strict '>' keeps first worst case.
  always_ff @(posedge clk) begin
    if (rst || w_start_take) begin
      r_err_count   <= '0;
      r_max_abs_err <= '0;
      r_sum_abs_err <= '0;
      r_worst_a     <= '0;
      r_worst_b     <= '0;
    end else if (w_cmp_valid && !abort) begin
      if (w_err_inc) r_err_count <= r_err_count + CW'(1);
      r_sum_abs_err <= w_sum_sat;
      if (w_abs_err > r_max_abs_err) begin
        r_max_abs_err <= w_abs_err;
        r_worst_a     <= w_cmp_a;
        r_worst_b     <= w_cmp_b;
      end
    end
  end

  assign op_a        = r_op_a;
  assign op_b        = r_op_b;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err_count   = r_err_count;
  assign max_abs_err = r_max_abs_err;
  assign sum_abs_err = r_sum_abs_err;
  assign worst_a     = r_worst_a;
  assign worst_b     = r_worst_b;

endmodule
